// File: rtl/ins_fetch_sequencer.sv
// Instruction fetch sequencer.
// Drives the instruction ROM address and waits out the ROM read latency.
// Checks the address tag returned with the data.
// Assembles one- or two-word instructions from the byte field word0[13:12].
// Presents each instruction to decode over a valid/ready handshake.
// Applies branch redirects on accept, and halts at end-of-program, on a
// halt request, or on a fetch error.
module ins_fetch_sequencer #(
    parameter int          ROM_LAT  = 2,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_LAST  = 16'h0008
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_addr_in,
    input  logic [15:0] rom_data,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] ir_word0,
    output logic [15:0] ir_word1,
    output logic        ir_len,
    output logic [15:0] ir_pc,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        running,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_DELIVER,
        S_HALT
    } state_t;

    // The wait counter only has to reach ROM_LAT, then it parks there.
    localparam int               CNT_W    = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LAT);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      pc;
    logic [CNT_W-1:0] cnt;

    logic        sample;
    logic        tag_ok;
    logic [1:0]  byte_f;
    logic [15:0] next_pc;
    logic        err_set;
    logic        restart;

    // ROM data lines up with rom_addr exactly ROM_LAT cycles after the address settles.
    assign sample  = (cnt == CNT_LAST);
    assign tag_ok  = (rom_addr_in == rom_addr);
    assign byte_f  = rom_data[13:12];
    // Sequential successor skips the immediate word of a two-word instruction.
    assign next_pc = branch_valid ? branch_target : (pc + 16'd1 + {15'd0, ir_len});

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision, plus the error/restart strobes the datapath follows.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        err_set   = 1'b0;
        restart   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH0;
                    restart   = 1'b1;
                end
            end
            S_FETCH0: begin
                if (sample) begin
                    if (!tag_ok) begin
                        state_nxt = S_HALT;
                        err_set   = 1'b1;
                    end else begin
                        case (byte_f)
                            2'b01: state_nxt = S_DELIVER;
                            2'b10: begin
                                // The second word would fall past the program end.
                                if (pc >= PC_LAST) begin
                                    state_nxt = S_HALT;
                                    err_set   = 1'b1;
                                end else begin
                                    state_nxt = S_FETCH1;
                                end
                            end
                            default: begin
                                state_nxt = S_HALT;
                                err_set   = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_FETCH1: begin
                if (sample) begin
                    if (tag_ok) begin
                        state_nxt = S_DELIVER;
                    end else begin
                        state_nxt = S_HALT;
                        err_set   = 1'b1;
                    end
                end
            end
            S_DELIVER: begin
                // halt_req and branch inputs only matter on the accept cycle.
                if (ir_ready) begin
                    if (halt_req) begin
                        state_nxt = S_HALT;
                    end else if (branch_valid) begin
                        if (branch_target > PC_LAST) begin
                            state_nxt = S_HALT;
                            err_set   = 1'b1;
                        end else begin
                            state_nxt = S_FETCH0;
                        end
                    end else if (next_pc > PC_LAST) begin
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_FETCH0;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    state_nxt = S_FETCH0;
                    restart   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        ir_valid = (state == S_DELIVER);
        running  = (state == S_FETCH0) || (state == S_FETCH1) || (state == S_DELIVER);
        halted   = (state == S_HALT);
    end

    // Datapath: PC, ROM address, latency counter, instruction register, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            rom_addr  <= 16'h0000;
            cnt       <= '0;
            ir_word0  <= 16'h0000;
            ir_word1  <= 16'h0000;
            ir_len    <= 1'b0;
            ir_pc     <= 16'h0000;
            fetch_err <= 1'b0;
        end else begin
            if (err_set) begin
                fetch_err <= 1'b1;
            end else if (restart) begin
                fetch_err <= 1'b0;
            end

            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc       <= RESET_PC;
                        rom_addr <= RESET_PC;
                        cnt      <= '0;
                    end
                end
                S_FETCH0: begin
                    if (!sample) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (state_nxt == S_DELIVER) begin
                        ir_word0 <= rom_data;
                        ir_word1 <= 16'h0000;
                        ir_len   <= 1'b0;
                        ir_pc    <= pc;
                    end else if (state_nxt == S_FETCH1) begin
                        ir_word0 <= rom_data;
                        rom_addr <= pc + 16'd1;
                        cnt      <= '0;
                    end
                end
                S_FETCH1: begin
                    if (!sample) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (state_nxt == S_DELIVER) begin
                        ir_word1 <= rom_data;
                        ir_len   <= 1'b1;
                        ir_pc    <= pc;
                    end
                end
                S_DELIVER: begin
                    if (state_nxt == S_FETCH0) begin
                        pc       <= next_pc;
                        rom_addr <= next_pc;
                        cnt      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_fetch_sequencer.sv
// Testbench for ins_fetch_sequencer.
// The stimulus process pushes the expected instructions into a queue.
// A monitor compares every presented instruction with the head of the queue
// and pops the entry on accept.
module tb_ins_fetch_sequencer;

    localparam int          ROM_LAT = 2;
    localparam logic [15:0] PC_LAST = 16'h0008;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic [15:0] rom_addr;
    logic [15:0] rom_addr_in;
    logic [15:0] rom_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_word0;
    logic [15:0] ir_word1;
    logic        ir_len;
    logic [15:0] ir_pc;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        running;
    logic        halted;
    logic        fetch_err;
    logic        corrupt;

    ins_fetch_sequencer #(
        .ROM_LAT (ROM_LAT),
        .RESET_PC(16'h0000),
        .PC_LAST (PC_LAST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .halt_req     (halt_req),
        .rom_addr     (rom_addr),
        .rom_addr_in  (rom_addr_in),
        .rom_data     (rom_data),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .ir_word0     (ir_word0),
        .ir_word1     (ir_word1),
        .ir_len       (ir_len),
        .ir_pc        (ir_pc),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .running      (running),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    // ROM model: registered read pipeline of ROM_LAT stages carrying data and address tag.
    logic [15:0] rom [0:255];
    logic [15:0] pd  [ROM_LAT];
    logic [15:0] pa  [ROM_LAT];

    always @(posedge clk) begin
        pd[0] <= rom[rom_addr[7:0]];
        pa[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) begin
            pd[i] <= pd[i-1];
            pa[i] <= pa[i-1];
        end
    end

    assign rom_data    = pd[ROM_LAT-1];
    assign rom_addr_in = pa[ROM_LAT-1] ^ (corrupt ? 16'h0100 : 16'h0000);

    typedef struct packed {
        logic [15:0] w0;
        logic [15:0] w1;
        logic        len;
        logic [15:0] pc;
    } ir_t;

    ir_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented instruction must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && ir_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ir: got ir_pc 0x%0h expected no instruction", ir_pc);
            end else begin
                check("ir_word0", 32'(ir_word0), 32'(exp_q[0].w0));
                check("ir_word1", 32'(ir_word1), 32'(exp_q[0].w1));
                check("ir_len",   32'(ir_len),   32'(exp_q[0].len));
                check("ir_pc",    32'(ir_pc),    32'(exp_q[0].pc));
                if (ir_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic fill_one_word();
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
    endtask

    task automatic push1(input int a);
        exp_q.push_back('{w0: rom[a], w1: 16'h0000, len: 1'b0, pc: 16'(a)});
    endtask

    task automatic push2(input int a);
        exp_q.push_back('{w0: rom[a], w1: rom[a+1], len: 1'b1, pc: 16'(a)});
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!ir_valid && n < 40) begin
            tick(1);
            n++;
        end
        if (!ir_valid) check("ir_valid_timeout", 32'(ir_valid), 1);
    endtask

    task automatic accept_one(input logic br, input logic [15:0] tgt, input logic hr);
        wait_valid();
        ir_ready      = 1'b1;
        branch_valid  = br;
        branch_target = tgt;
        halt_req      = hr;
        tick(1);
        ir_ready      = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 16'h0000;
        halt_req      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; ir_ready = 1'b0;
        branch_valid = 1'b0; branch_target = 16'h0000; corrupt = 1'b0;
        fill_one_word();
        #12;
        // Reset state
        check("rst_rom_addr",  32'(rom_addr),  0);
        check("rst_ir_valid",  32'(ir_valid),  0);
        check("rst_ir_word0",  32'(ir_word0),  0);
        check("rst_ir_pc",     32'(ir_pc),     0);
        check("rst_running",   32'(running),   0);
        check("rst_halted",    32'(halted),    0);
        check("rst_fetch_err", 32'(fetch_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // Run 1: single-word program 0..8, latency, backpressure, end-of-program
        rom[0] = 16'h1B5C;
        rom[1] = 16'h1015;
        for (int a = 0; a <= 8; a++) push1(a);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 1;
        check("start_rom_addr", 32'(rom_addr), 0);
        check("start_running",  32'(running),  1);
        while (!ir_valid && n < 20) begin
            tick(1);
            n++;
        end
        check("first_ir_latency", 32'(n), 1 + ROM_LAT + 1);
        for (int a = 0; a < 3; a++) accept_one(1'b0, 16'h0000, 1'b0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_ir_valid", 32'(ir_valid), 1);
            check("bp_rom_addr", 32'(rom_addr), 3);
            tick(1);
        end
        for (int a = 3; a <= 8; a++) accept_one(1'b0, 16'h0000, 1'b0);
        check("eop_halted",    32'(halted),    1);
        check("eop_running",   32'(running),   0);
        check("eop_fetch_err", 32'(fetch_err), 0);
        tick(6);
        check("eop_halted_hold", 32'(halted), 1);
        check("eop_drained", 32'(exp_q.size()), 0);

        // Run 2: two-word instruction, then an illegal byte field
        rom[0] = 16'h1B5C; rom[1] = 16'h2C40; rom[2] = 16'h85A1;
        rom[3] = 16'h101D; rom[4] = 16'h0000;
        exp_q.push_back('{w0: 16'h1B5C, w1: 16'h0000, len: 1'b0, pc: 16'h0000});
        exp_q.push_back('{w0: 16'h2C40, w1: 16'h85A1, len: 1'b1, pc: 16'h0001});
        exp_q.push_back('{w0: 16'h101D, w1: 16'h0000, len: 1'b0, pc: 16'h0003});
        start_run();
        for (int i = 0; i < 3; i++) accept_one(1'b0, 16'h0000, 1'b0);
        tick(8);
        check("illegal_fetch_err", 32'(fetch_err), 1);
        check("illegal_halted",    32'(halted),    1);
        check("illegal_ir_valid",  32'(ir_valid),  0);
        check("illegal_drained",   32'(exp_q.size()), 0);

        // Run 3: branch back to 2, then branch beyond PC_LAST
        fill_one_word();
        for (int a = 0; a <= 5; a++) push1(a);
        for (int a = 2; a <= 5; a++) push1(a);
        start_run();
        check("restart_fetch_err", 32'(fetch_err), 0);
        check("restart_halted",    32'(halted),    0);
        for (int a = 0; a <= 4; a++) accept_one(1'b0, 16'h0000, 1'b0);
        accept_one(1'b1, 16'h0002, 1'b0);
        check("branch_rom_addr", 32'(rom_addr), 2);
        for (int a = 2; a <= 4; a++) accept_one(1'b0, 16'h0000, 1'b0);
        accept_one(1'b1, 16'h0020, 1'b0);
        check("bad_branch_fetch_err", 32'(fetch_err), 1);
        check("bad_branch_halted",    32'(halted),    1);
        check("bad_branch_rom_addr",  32'(rom_addr),  5);
        check("branch_drained", 32'(exp_q.size()), 0);

        // Run 4: halt_req on accept, then a corrupted address tag
        push1(0);
        start_run();
        accept_one(1'b0, 16'h0000, 1'b1);
        check("halt_req_halted",    32'(halted),    1);
        check("halt_req_fetch_err", 32'(fetch_err), 0);
        tick(4);
        check("halt_req_running", 32'(running), 0);
        push1(0);
        start_run();
        accept_one(1'b0, 16'h0000, 1'b0);
        corrupt = 1'b1;
        tick(8);
        check("tag_fetch_err", 32'(fetch_err), 1);
        check("tag_halted",    32'(halted),    1);
        corrupt = 1'b0;
        check("tag_drained", 32'(exp_q.size()), 0);

        // Run 5: two-word instruction at PC_LAST is not fetched
        rom[8] = 16'h2008;
        for (int a = 0; a <= 7; a++) push1(a);
        start_run();
        for (int a = 0; a <= 7; a++) accept_one(1'b0, 16'h0000, 1'b0);
        tick(8);
        check("last_two_fetch_err", 32'(fetch_err), 1);
        check("last_two_halted",    32'(halted),    1);
        check("last_two_rom_addr",  32'(rom_addr),  8);
        check("last_two_drained",   32'(exp_q.size()), 0);

        // Run 6: asynchronous reset in the middle of FETCH1
        rom[0] = 16'h2C40; rom[1] = 16'h85A1;
        start_run();
        tick(3);
        check("pre_rst_rom_addr", 32'(rom_addr), 1);
        check("pre_rst_running",  32'(running),  1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rom_addr",  32'(rom_addr),  0);
        check("async_rst_ir_word0",  32'(ir_word0),  0);
        check("async_rst_ir_word1",  32'(ir_word1),  0);
        check("async_rst_ir_len",    32'(ir_len),    0);
        check("async_rst_running",   32'(running),   0);
        check("async_rst_halted",    32'(halted),    0);
        check("async_rst_fetch_err", 32'(fetch_err), 0);
        check("async_rst_ir_valid",  32'(ir_valid),  0);
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_idle_running", 32'(running), 0);
        check("post_rst_idle_halted",  32'(halted),  0);

        check("final_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ins_fetch_sequencer.md
Name: ins_fetch_sequencer

Overview:
Instruction fetch controller sitting between the program counter and the instruction ROM. It drives the ROM address, waits out the ROM's registered read latency, and checks the returned address tag. It assembles one- or two-word instructions from the byte field, word0[13:12], and hands each complete instruction to the decode stage over a valid/ready handshake. It also applies branch redirects and halts at end-of-program or on a fetch error.

Parameters:
ROM_LAT, 2, cycles from rom_addr stable to matching rom_data/rom_addr_in valid (>=1)
RESET_PC, 16'h0000, PC loaded on reset and on start
PC_LAST, 16'h0008, last valid ROM address; an instruction ending beyond it ends the program

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin fetching from RESET_PC (IDLE or HALT only)
halt_req  in  1  stop after the current instruction is accepted
rom_addr  out  16  ROM address, registered
rom_addr_in  in  16  address tag returned with ROM data
rom_data  in  16  ROM instruction word
ir_valid  out  1  instruction available to decode
ir_ready  in  1  decode accepts instruction
ir_word0  out  16  first instruction word
ir_word1  out  16  second word (immediate/address); 0 for one-word instructions
ir_len  out  1  0 = one word, 1 = two words
ir_pc  out  16  address of ir_word0
branch_valid  in  1  redirect PC, sampled only on the accept cycle
branch_target  in  16  redirect address
running  out  1  state is not IDLE or HALT
halted  out  1  state == HALT
fetch_err  out  1  sticky error flag, cleared by reset or start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, rom_addr=0.
  - ir_valid=0; ir_word0, ir_word1, ir_pc, ir_len = 0.
  - halted=0, fetch_err=0, wait counter=0.
  - Reset mid-fetch discards everything in flight.
- States: IDLE, FETCH0, FETCH1, DELIVER, HALT.
- IDLE:
  - start=1 -> pc=RESET_PC; rom_addr<=RESET_PC; cnt=0; go FETCH0.
- FETCH0:
  - rom_addr is held.
  - cnt increments each cycle.
  - On the cycle cnt==ROM_LAT, sample rom_data and rom_addr_in.
  - Tag check: rom_addr_in != rom_addr -> fetch_err=1, go HALT.
  - Byte field 2'b01 -> ir_word0=rom_data, ir_word1=0, ir_len=0, go DELIVER.
  - Byte field 2'b10 -> ir_word0=rom_data; rom_addr<=pc+1 (16-bit wrap); cnt=0; go FETCH1.
  - Byte field 2'b00 or 2'b11 -> illegal: fetch_err=1, go HALT.
  - Worked latency, ROM_LAT=2: rom_addr valid in cycle t, data sampled at end of t+2, ir_valid=1 in t+3.
- FETCH1:
  - Same wait and tag check; capture ir_word1=rom_data, ir_len=1, go DELIVER.
  - Two-word instruction at pc==PC_LAST -> fetch_err=1, go HALT without issuing the fetch.
- DELIVER:
  - ir_valid=1; ir_word0, ir_word1, ir_len and ir_pc=pc are held stable until ir_valid&&ir_ready.
  - On accept, ir_valid drops the next cycle.
  - next_pc = branch_valid ? branch_target : pc+1+ir_len, wrapping mod 2^16.
  - If halt_req=1, or !branch_valid and next_pc > PC_LAST -> go HALT.
  - If branch_valid and branch_target > PC_LAST -> fetch_err=1, go HALT.
  - Otherwise pc=next_pc, rom_addr<=next_pc, cnt=0, go FETCH0.
  - halt_req or branch_valid without an accept has no effect.
- HALT:
  - halted=1, ir_valid=0, rom_addr holds.
  - start=1 -> clears fetch_err, restarts as from IDLE.
- start is ignored outside IDLE/HALT.
- halt_req during FETCH0/FETCH1 is not latched; it must be asserted on the accept cycle.

Test Plan:
- Single-word fetch: ROM[0]=16'h1B5C, ROM[1]=16'h1015. Pulse start in cycle 0 -> rom_addr=0, first ir_valid with ir_word0=16'h1B5C, ir_len=0, ir_pc=0 exactly 1+ROM_LAT+1 cycles after start. With ir_ready=1, next instruction has ir_pc=1.
- Two-word fetch: ROM[1]=16'h2C40, ROM[2]=16'h85A1, ROM[3]=16'h101D -> ir_word0=16'h2C40, ir_word1=16'h85A1, ir_len=1, ir_pc=1. Next ir_pc=3.
- Backpressure: hold ir_ready=0 for 5 cycles in DELIVER -> ir_valid and all ir_* outputs stable, no ROM address change. Release -> exactly one accept.
- Branch: accept at ir_pc=5 with branch_valid=1, branch_target=16'h0002 -> rom_addr=2 next cycle, next ir_pc=2. branch_target=16'h0020 -> fetch_err=1, halted=1.
- Errors: ROM[4]=16'h0000 (byte 00) -> fetch_err=1, halted=1, no ir_valid. Corrupt rom_addr_in on a sample cycle -> fetch_err=1. start in HALT clears fetch_err and refetches from 0.
- End-of-program and reset: run ROM 0..8 of one-word instructions -> halted after accepting ir_pc=8. Drop rst_n mid-FETCH1 -> all outputs return to reset values immediately, asynchronously.
